// File: rtl/iterative_shift_add_pkg.sv
// Shared types, constants and helpers for the iterative shift-add engine.
package iter_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation modes.
  localparam logic MODE_MUL = 1'b0;  // shift-add multiply
  localparam logic MODE_REP = 1'b1;  // repeat-accumulate

  // Widest vector xnor_reduce accepts; narrower values are zero-extended,
  // which leaves the parity, and therefore the result, unchanged.
  localparam int XNOR_MAX_WIDTH = 256;

  // Reduction XNOR: 1 when the vector has an even number of set bits.
  function automatic logic xnor_reduce(input logic [XNOR_MAX_WIDTH-1:0] value);
    return ~^value;
  endfunction

  // Counter width must hold both WIDTH (mode 0 load) and 2**WIDTH-1
  // (largest mode 1 repeat count), so it is never narrower than WIDTH.
  function automatic int cnt_width(input int width);
    int c;
    c = $clog2(width + 1);
    return (c > width) ? c : width;
  endfunction

endpackage

// File: rtl/iterative_shift_add_if.sv
// Request/response bundle between a requester and the shift-add engine.
interface iterative_shift_add_if
  import iter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2 * WIDTH,
  parameter int CNT_WIDTH = cnt_width(WIDTH)
);

  logic                 start;
  logic                 mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic [ACC_WIDTH-1:0] result;
  logic                 result_xnor;
  logic [CNT_WIDTH-1:0] iter;

  // Requester side.
  modport master (
    output start, mode, a, b,
    input  ready, busy, done, result, result_xnor, iter
  );

  // Engine side.
  modport slave (
    input  start, mode, a, b,
    output ready, busy, done, result, result_xnor, iter
  );

endinterface

// File: rtl/iterative_shift_add_loop_counter.sv
// Down-counter that paces the iterations of one operation.
module loop_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 dec,
  output logic                 last,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

  assign last = (count == CNT_WIDTH'(1));
  assign zero = (count == '0);

endmodule

// File: rtl/iterative_shift_add.sv
// Multi-cycle unsigned multiply / repeat-accumulate engine, one step per clock.
module iterative_shift_add
  import iter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2 * WIDTH,
  parameter int CNT_WIDTH = cnt_width(WIDTH)
) (
  input logic                 clock,
  input logic                 reset,
  iterative_shift_add_if.slave bus
);

  state_t               state;
  logic                 mode_q;
  logic [ACC_WIDTH-1:0] mcand;
  logic [WIDTH-1:0]     mplier;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] step_add;
  logic [ACC_WIDTH-1:0] acc_next;

  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic [ACC_WIDTH-1:0] result_q;
  logic                 result_xnor_q;
  logic [CNT_WIDTH-1:0] iter_q;

  logic                 accept;
  logic [CNT_WIDTH-1:0] load_value;
  logic                 cnt_last;
  logic                 cnt_zero;

  // A request is taken in IDLE and also in DONE, so operations can chain
  // with no bubble.
  assign accept     = bus.start && ((state == IDLE) || (state == DONE));
  assign load_value = (bus.mode == MODE_MUL) ? CNT_WIDTH'(WIDTH)
                                             : CNT_WIDTH'(bus.b);

  loop_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_loop_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (load_value),
    .dec        (state == RUN),
    .last       (cnt_last),
    .zero       (cnt_zero)
  );

  // Addend for the current iteration: gated by the multiplier LSB in
  // multiply mode, always the captured operand in repeat mode.
  always_comb begin
    // NOTE: a default first means every path assigns, so no latch is inferred.
    step_add = '0;
    if (mode_q == MODE_REP) begin
      step_add = mcand;
    end else if (mplier[0]) begin
      step_add = mcand;
    end
  end

  assign acc_next = acc + step_add;

  // Controller and datapath: state, operand registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      mode_q        <= MODE_MUL;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      result_xnor_q <= 1'b1;
      iter_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            mcand  <= ACC_WIDTH'(bus.a);
            mplier <= bus.b;
            acc    <= '0;
            iter_q <= '0;
            if (load_value != '0) begin
              state   <= RUN;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              // Zero-length operation: finish straight away with result 0.
              state         <= DONE;
              ready_q       <= 1'b1;
              busy_q        <= 1'b0;
              done_q        <= 1'b1;
              result_q      <= '0;
              result_xnor_q <= xnor_reduce('0);
            end
          end else begin
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        RUN: begin
          acc    <= acc_next;
          iter_q <= iter_q + CNT_WIDTH'(1);
          if (mode_q == MODE_MUL) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          // The zero check only guards against a stuck run; the last flag
          // is the normal exit.
          if (cnt_last || cnt_zero) begin
            state         <= DONE;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            result_q      <= acc_next;
            result_xnor_q <= xnor_reduce(XNOR_MAX_WIDTH'(acc_next));
          end
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.result_xnor = result_xnor_q;
  assign bus.iter        = iter_q;

endmodule
